// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the fetch sequencer's control, memory and IF/ID slot signals.
// master = the sequencer, slave = its environment (ID stage, hazard unit, imem).
interface fetch_ctrl_if;
    logic        stall;
    logic        pc_src;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        misalign;

    modport master (
        input  stall, pc_src, next_pc, imem_ack, imem_rdata,
        output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, misalign
    );

    modport slave (
        output stall, pc_src, next_pc, imem_ack, imem_rdata,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, misalign
    );
endinterface

// File: rtl/fetch_ctrl_if_slot.sv
// One-entry IF/ID output register. Kill wins over fill, fill wins over consume.
module fetch_ctrl_if_slot (
    input  logic        clk,
    input  logic        rst,
    input  logic        fill_i,
    input  logic        consume_i,
    input  logic        kill_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;

    // Next slot contents from the fill/consume/kill controls.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (kill_i) begin
            valid_d = 1'b0;
        end else if (fill_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            pc_q    <= 32'h0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + 32'd4;
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the imem handshake and
// drops wrong-path fetches in flight when a redirect is accepted.
//
// state   | meaning
// FETCH   | requesting imem at pc; slot fills on ack
// HOLD    | slot full and stalled; no request until stall drops
// DISCARD | stale request outstanding; drop its data, pc holds the target
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    fetch_ctrl_if.master    bus
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  stale_q, stale_d;
    logic         misalign_q, misalign_d;

    logic         req;
    logic [31:0]  addr;
    logic         fill;
    logic         kill;
    logic         slot_valid;
    logic         consume;
    logic         redirect;
    logic [31:0]  target;

    // pc_src only counts when the hazard unit is not stalling; it reasserts otherwise.
    assign redirect = bus.pc_src && !bus.stall;
    assign target   = word_align(bus.next_pc);
    assign consume  = slot_valid && !bus.stall;

    // Next-state, pc update and handshake outputs.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        stale_d    = stale_q;
        misalign_d = 1'b0;
        req        = 1'b0;
        addr       = pc_q;
        fill       = 1'b0;
        kill       = 1'b0;
        if (!rst) begin
            misalign_d = redirect && (bus.next_pc[1:0] != 2'b00);
            case (state_q)
                ST_FETCH: begin
                    if (slot_valid && bus.stall) begin
                        state_d = ST_HOLD;
                    end else begin
                        req = 1'b1;
                        if (bus.imem_ack) begin
                            if (redirect) begin
                                // Acked word is the pc+8 wrong path.
                                kill = 1'b1;
                                pc_d = target;
                            end else begin
                                fill = 1'b1;
                                pc_d = pc_q + 32'd4;
                            end
                        end else if (redirect) begin
                            stale_d = pc_q;
                            pc_d    = target;
                            state_d = ST_DISCARD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!bus.stall) begin
                        state_d = ST_FETCH;
                        if (redirect) begin
                            pc_d = target;
                        end
                    end
                end
                ST_DISCARD: begin
                    // Keep the stale address stable until imem completes it.
                    req  = 1'b1;
                    addr = stale_q;
                    if (redirect) begin
                        pc_d = target;
                    end
                    if (bus.imem_ack) begin
                        kill    = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            stale_q    <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            stale_q    <= stale_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_ctrl_if_slot u_slot (
        .clk        (clk),
        .rst        (rst),
        .fill_i     (fill),
        .consume_i  (consume),
        .kill_i     (kill),
        .instr_i    (bus.imem_rdata),
        .pc_i       (pc_q),
        .valid_o    (slot_valid),
        .instr_o    (bus.if_instr),
        .pc_o       (bus.if_pc),
        .pc_plus4_o (bus.if_pc_plus4)
    );

    assign bus.if_valid  = slot_valid;
    assign bus.imem_req  = req;
    assign bus.imem_addr = word_align(addr);
    assign bus.misalign  = misalign_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: behavioural model checked every cycle, plus directed
// literal expectations and a randomised stall/redirect/latency phase.
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   lat      = 0;
    int   cnt      = 0;
    logic ack_force = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // Memory: acks once the request has been held for lat cycles.
    always_comb begin
        bus.imem_ack   = (bus.imem_req && (cnt >= lat)) || ack_force;
        bus.imem_rdata = mem_word(bus.imem_addr);
    end

    always @(posedge clk) begin
        if (rst)                                cnt <= 0;
        else if (bus.imem_req && !bus.imem_ack) cnt <= cnt + 1;
        else                                    cnt <= 0;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pc, slot contents and "discarding"/"holding" flags.
    logic        m_init = 1'b0;
    logic [31:0] m_pc, m_stale, m_si, m_sp;
    logic        m_sv, m_discard, m_hold, m_mis;

    initial begin
        logic        e_req, redir, acc, fill, kill;
        logic [31:0] e_addr, tgt;
        forever begin
            @(negedge clk);
            if (rst)                               e_req = 1'b0;
            else if (m_discard)                    e_req = 1'b1;
            else if (m_hold || (m_sv && bus.stall)) e_req = 1'b0;
            else                                   e_req = 1'b1;
            e_addr = m_discard ? m_stale : m_pc;
            if (m_init) begin
                check1("imem_req", bus.imem_req, e_req);
                if (e_req) check32("imem_addr", bus.imem_addr, e_addr);
                check1("if_valid", bus.if_valid, m_sv);
                if (m_sv) begin
                    check32("if_instr", bus.if_instr, m_si);
                    check32("if_pc", bus.if_pc, m_sp);
                    check32("if_pc_plus4", bus.if_pc_plus4, m_sp + 32'd4);
                end
                check1("misalign", bus.misalign, m_mis);
            end
            if (rst) begin
                m_init = 1'b1; m_pc = 32'h0000_3000; m_stale = 32'h0;
                m_sv = 1'b0; m_si = 32'h0; m_sp = 32'h0;
                m_discard = 1'b0; m_hold = 1'b0; m_mis = 1'b0;
            end else begin
                redir = bus.pc_src && !bus.stall;
                tgt   = {bus.next_pc[31:2], 2'b00};
                acc   = e_req && bus.imem_ack;
                fill  = 1'b0;
                kill  = 1'b0;
                m_mis = redir && (bus.next_pc[1:0] != 2'b00);
                if (m_discard) begin
                    if (acc) begin kill = 1'b1; m_discard = 1'b0; end
                    if (redir) m_pc = tgt;
                end else if (e_req) begin
                    if (acc && redir) begin kill = 1'b1; m_pc = tgt; end
                    else if (acc) fill = 1'b1;
                    else if (redir) begin m_stale = m_pc; m_pc = tgt; m_discard = 1'b1; end
                end else begin
                    if (bus.stall) m_hold = 1'b1;
                    else begin m_hold = 1'b0; if (redir) m_pc = tgt; end
                end
                if (kill) m_sv = 1'b0;
                else if (fill) begin
                    m_sv = 1'b1; m_si = mem_word(m_pc); m_sp = m_pc; m_pc = m_pc + 32'd4;
                end else if (m_sv && !bus.stall) m_sv = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        bus.stall = 1'b0; bus.pc_src = 1'b0; bus.next_pc = 32'h0;
        rst = 1'b1; ack_force = 1'b1;
        step();
        at_neg();
        check1("rst_req", bus.imem_req, 1'b0);
        check1("rst_valid", bus.if_valid, 1'b0);
        check32("rst_if_pc", bus.if_pc, 32'h0);
        check32("rst_if_instr", bus.if_instr, 32'h0);
        check1("rst_misalign", bus.misalign, 1'b0);
        step();
        ack_force = 1'b0; rst = 1'b0;
        at_neg();                                     // A
        check32("a_addr", bus.imem_addr, 32'h3000);
        check1("a_valid", bus.if_valid, 1'b0);
        step(); at_neg();                             // B
        check32("b_addr", bus.imem_addr, 32'h3004);
        check32("b_if_pc", bus.if_pc, 32'h3000);
        step(); bus.stall = 1'b1; at_neg();           // C
        check1("hold_req", bus.imem_req, 1'b0);
        check32("hold_if_pc", bus.if_pc, 32'h3004);
        step(); step();                               // D, E
        check32("hold_if_pc_e", bus.if_pc, 32'h3004);
        step(); bus.stall = 1'b0; lat = 2; at_neg();  // F
        check1("unstall_req", bus.imem_req, 1'b0);
        step(); bus.pc_src = 1'b1; bus.next_pc = 32'h3100; at_neg(); // G
        check32("g_addr", bus.imem_addr, 32'h3008);
        step(); bus.pc_src = 1'b0; at_neg();          // H
        check32("disc_addr", bus.imem_addr, 32'h3008);
        step();                                       // I: stale ack
        step(); lat = 0; at_neg();                    // J
        check32("redir_addr", bus.imem_addr, 32'h3100);
        check1("redir_valid", bus.if_valid, 1'b0);
        step(); bus.pc_src = 1'b1; bus.next_pc = 32'h4000; at_neg(); // K
        check32("k_if_pc", bus.if_pc, 32'h3100);
        step(); bus.pc_src = 1'b0; at_neg();          // L
        check1("same_ack_valid", bus.if_valid, 1'b0);
        check32("same_ack_addr", bus.imem_addr, 32'h4000);
        step(); lat = 3; bus.pc_src = 1'b1; bus.next_pc = 32'h5000; at_neg(); // M
        check32("m_if_pc", bus.if_pc, 32'h4000);
        step(); bus.next_pc = 32'h6000; at_neg();     // N
        check32("n_addr", bus.imem_addr, 32'h4004);
        step(); bus.pc_src = 1'b0;                    // O
        step();                                       // P: stale ack
        step(); lat = 0; at_neg();                    // Q
        check32("last_redir_addr", bus.imem_addr, 32'h6000);
        step(); bus.pc_src = 1'b1; bus.next_pc = 32'h3102; at_neg(); // R
        step(); bus.pc_src = 1'b0; at_neg();          // S
        check1("misalign_pulse", bus.misalign, 1'b1);
        check32("misalign_addr", bus.imem_addr, 32'h3100);
        step(); lat = 2; at_neg();                    // T
        check1("misalign_clear", bus.misalign, 1'b0);
        step(); rst = 1'b1; at_neg();                 // U
        check1("midrst_req", bus.imem_req, 1'b0);
        step(); rst = 1'b0; lat = 0; at_neg();        // V
        check1("midrst_valid", bus.if_valid, 1'b0);
        check32("midrst_addr", bus.imem_addr, 32'h3000);
        step(); bus.pc_src = 1'b1; bus.next_pc = 32'hFFFF_FFF8; at_neg(); // W
        step(); bus.pc_src = 1'b0;                    // X
        step();                                       // Y
        step(); at_neg();                             // Z
        check32("wrap_addr", bus.imem_addr, 32'h0);
        check32("wrap_if_pc", bus.if_pc, 32'hFFFF_FFFC);
        check32("wrap_plus4", bus.if_pc_plus4, 32'h0);

        for (int i = 0; i < 400; i++) begin
            step();
            bus.stall   = ($urandom_range(0, 3) == 0);
            bus.pc_src  = ($urandom_range(0, 7) == 0);
            bus.next_pc = $urandom();
            ack_force   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) lat = $urandom_range(0, 3);
            rst         = ($urandom_range(0, 99) == 0);
        end
        step();
        bus.stall = 1'b0; bus.pc_src = 1'b0; ack_force = 1'b0; rst = 1'b0;
        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the architectural PC register and drives the instruction-memory request handshake. It consumes the redirect decision (pc_src, next_pc) from the next-PC selector in ID, honours hazard-unit stalls, and presents one fetched instruction per cycle to the IF/ID register. It discards wrong-path fetches that are already in flight when a redirect arrives, while keeping MIPS delay-slot semantics intact.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset; first fetch address.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  hazard unit: IF/ID frozen, output slot not consumed this cycle
pc_src  in  1  redirect request from next-PC selector; sampled only when stall=0
next_pc  in  32  redirect target, valid with pc_src
imem_req  out  1  instruction-memory request
imem_addr  out  32  request address, word aligned ([1:0] forced 2'b00)
imem_ack  in  1  memory accepts the request and returns data this cycle; ignored unless imem_req=1
imem_rdata  in  32  instruction word, valid with imem_ack
if_valid  out  1  output slot holds a valid instruction
if_instr  out  32  fetched instruction
if_pc  out  32  address of if_instr
if_pc_plus4  out  32  if_pc+4, modulo 2^32
misalign  out  1  one-cycle pulse: accepted redirect target had [1:0]!=0

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=FETCH, if_valid=0, if_instr=0, if_pc=0, misalign=0. imem_req=0 while rst=1. Any imem_ack during rst is ignored. A reset in mid-transaction abandons it; imem resets on the same rst.
- Output slot consumed at an edge iff if_valid=1 && stall=0.
- State FETCH: imem_req=1, imem_addr=pc. Address held stable until ack.
  - On ack, with the slot empty or being consumed: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4. Stay in FETCH, so the next request issues the following cycle. Throughput is 1 instr/cycle with a zero-wait memory.
  - If the slot is full and stalled: do not assert imem_req; go to HOLD.
- State HOLD: imem_req=0. Leave for FETCH on the first cycle with stall=0.
- Redirect (pc_src=1 && stall=0):
  - The instruction in the slot (the delay slot) is consumed normally.
  - pc<=next_pc with [1:0] cleared. misalign pulses if next_pc[1:0]!=0.
  - If a request is outstanding with no ack this cycle: latch the target, go to DISCARD.
  - If ack arrives in the same cycle: drop imem_rdata (that fetch is pc+8 wrong path), set if_valid<=0, and request the target next cycle from FETCH.
  - If in HOLD or idle: go straight to FETCH at the target.
- State DISCARD: imem_req=1 at the stale address until ack. On ack, drop the data, set if_valid<=0, go to FETCH at the latched target.
  - A second redirect in DISCARD overwrites the target; last one wins.
- Stall with pc_src=1: pc_src is ignored; the hazard unit reasserts it.
- No write to pc occurs except on a slot fill (+4), a redirect, or reset.
- PC wrap: 32'hFFFF_FFFC+4 = 0. No error is flagged.

Decomposition:
- Shared package holds the state encoding (FETCH=2'd0, HOLD=2'd1, DISCARD=2'd2), RESET_PC default and the word-align mask.
- One natural sub-module: if_slot, the one-entry output register with fill, consume and kill controls.

Test Plan:
- Reset, zero-wait memory: imem_addr = 3000, 3004, 3008 on consecutive cycles. if_pc trails by 1 cycle, with if_valid=1 from the 2nd cycle.
- Stall for 3 cycles with the slot full: imem_req=0 during HOLD, and if_instr/if_pc stay stable at 3004. Fetch resumes at 3008 one cycle after stall drops.
- 2-cycle memory latency, pc_src=1 with next_pc=0x3100 while 0x3008 is outstanding: the 0x3008 data is dropped and the next imem_addr is 0x3100. The delay slot 0x3004 is delivered once.
- pc_src and imem_ack in the same cycle (target 0x4000): no if_valid for the acked word, and the request goes to 0x4000 on the next cycle.
- Two redirects during DISCARD (0x5000, then 0x6000): the fetch after the stale ack is 0x6000.
- Redirect to 0x3102: misalign pulses for one cycle and imem_addr=0x3100. Also assert rst mid-request: the next cycle shows if_valid=0 and the fetch restarts at 0x3000.
